// File: rtl/kernel_shell_pkg.sv
// Shared types and length/count helpers for the kernel memory shell.
package kernel_shell_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_RUN,
        ST_WRITE,
        ST_DONE
    } state_t;

    localparam int DEF_ADDR_WID  = 12;
    localparam int DEF_BANK_BITS = 2;

    // A run is rejected when nothing would be loaded or either transfer overruns the scratchpad.
    function automatic logic len_bad(input logic [63:0] num_rd,
                                     input logic [63:0] num_wr,
                                     input int unsigned addr_wid);
        logic [63:0] depth;
        depth = 64'd1 << addr_wid;
        return (num_rd == 64'd0) || (num_rd > depth) || (num_wr > depth);
    endfunction

    function automatic logic cnt_more(input logic [63:0] cnt, input logic [63:0] num);
        return (cnt + 64'd1) < num;
    endfunction

endpackage

// File: rtl/shell_bank_ram.sv
// One scratchpad bank: PORTS kernel ports plus one host load/store port.
// Kernel reads registered (1 cycle, read-before-write); host read is combinational.
// No backpressure; lowest kernel port index wins on same-address writes.
module shell_bank_ram #(
    parameter int DATA_WID = 32,
    parameter int LA       = 10,
    parameter int PORTS    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      kern_en,
    input  logic [PORTS*LA-1:0]       k_addr,
    input  logic [PORTS-1:0]          k_ce,
    input  logic [PORTS-1:0]          k_we,
    input  logic [PORTS*DATA_WID-1:0] k_d,
    output logic [PORTS*DATA_WID-1:0] k_q,
    input  logic                      host_we,
    input  logic [LA-1:0]             host_addr,
    input  logic [DATA_WID-1:0]       host_d,
    output logic [DATA_WID-1:0]       host_q
);

    logic [DATA_WID-1:0] mem [2**LA];

    // Highest index first so the lowest port's write lands last.
    always_ff @(posedge clk) begin
        if (host_we)
            mem[host_addr] <= host_d;
        if (kern_en)
            for (int p = PORTS - 1; p >= 0; p--)
                if (k_ce[p] && k_we[p])
                    mem[k_addr[p*LA +: LA]] <= k_d[p*DATA_WID +: DATA_WID];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            k_q <= '0;
        else if (kern_en)
            for (int p = 0; p < PORTS; p++)
                if (k_ce[p] && !k_we[p])
                    k_q[p*DATA_WID +: DATA_WID] <= mem[k_addr[p*LA +: LA]];
    end

    assign host_q = mem[host_addr];

endmodule

// File: rtl/kernel_mem_shell.sv
// Host<->kernel memory shell: load scratchpad, run kernel, store results, count cycles.
// start->read_enable 1 cycle; final read -> k_start next cycle; k_done -> write_enable next cycle.
// Host channels advance only on read_ready/write_ready; one word per cycle when always ready.
module kernel_mem_shell
    import kernel_shell_pkg::*;
#(
    parameter int DATA_WID  = 32,
    parameter int ADDR_WID  = DEF_ADDR_WID,
    parameter int BANK_BITS = DEF_BANK_BITS,
    parameter int PORTS     = 2,
    localparam int NB = 2**BANK_BITS,
    localparam int P  = NB * PORTS,
    localparam int LA = ADDR_WID - BANK_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [63:0]           read_base,
    input  logic [63:0]           write_base,
    input  logic [63:0]           num_read,
    input  logic [63:0]           num_write,
    input  logic [63:0]           stride,
    input  logic                  read_ready,
    input  logic [DATA_WID-1:0]   read_data,
    input  logic                  write_ready,
    output logic                  read_enable,
    output logic                  write_enable,
    output logic [63:0]           read_addr,
    output logic [63:0]           write_addr,
    output logic [63:0]           read_size,
    output logic [63:0]           write_size,
    output logic                  finish_read,
    output logic                  finish_write,
    output logic [DATA_WID-1:0]   write_data,
    output logic                  done,
    output logic                  error,
    output logic [63:0]           cycles,
    output logic                  k_start,
    input  logic                  k_done,
    input  logic [P*LA-1:0]       k_addr,
    input  logic [P-1:0]          k_ce,
    input  logic [P-1:0]          k_we,
    input  logic [P*DATA_WID-1:0] k_d,
    output logic [P*DATA_WID-1:0] k_q
);

    state_t              state;
    logic [63:0]         read_cnt, write_cnt, write_next;
    logic [63:0]         num_read_r, num_write_r;
    logic [ADDR_WID-1:0] host_addr;
    logic [BANK_BITS-1:0] host_bank;
    logic                host_we, kern_en;
    logic [DATA_WID-1:0] bank_q [NB];
    logic [DATA_WID-1:0] host_q;

    assign write_next = write_cnt + 64'd1;
    assign kern_en    = (state == ST_RUN);
    assign host_we    = (state == ST_READ) && read_ready;

    // Outside READ/WRITE the host port points at word 0, ready for the write-back preload.
    always_comb begin
        host_addr = '0;
        if (state == ST_READ)
            host_addr = read_cnt[ADDR_WID-1:0];
        else if (state == ST_WRITE)
            host_addr = write_next[ADDR_WID-1:0];
    end

    assign host_bank = host_addr[ADDR_WID-1 -: BANK_BITS];
    assign host_q    = bank_q[host_bank];

    for (genvar b = 0; b < NB; b++) begin : g_bank
        shell_bank_ram #(
            .DATA_WID (DATA_WID),
            .LA       (LA),
            .PORTS    (PORTS)
        ) u_ram (
            .clk       (clk),
            .reset     (reset),
            .kern_en   (kern_en),
            .k_addr    (k_addr[b*PORTS*LA +: PORTS*LA]),
            .k_ce      (k_ce[b*PORTS +: PORTS]),
            .k_we      (k_we[b*PORTS +: PORTS]),
            .k_d       (k_d[b*PORTS*DATA_WID +: PORTS*DATA_WID]),
            .k_q       (k_q[b*PORTS*DATA_WID +: PORTS*DATA_WID]),
            .host_we   (host_we && (host_bank == BANK_BITS'(b))),
            .host_addr (host_addr[LA-1:0]),
            .host_d    (read_data),
            .host_q    (bank_q[b])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            read_cnt     <= '0;
            write_cnt    <= '0;
            num_read_r   <= '0;
            num_write_r  <= '0;
            read_enable  <= 1'b0;
            write_enable <= 1'b0;
            read_addr    <= '0;
            write_addr   <= '0;
            read_size    <= '0;
            write_size   <= '0;
            finish_read  <= 1'b0;
            finish_write <= 1'b0;
            write_data   <= '0;
            done         <= 1'b0;
            error        <= 1'b0;
            cycles       <= '0;
            k_start      <= 1'b0;
        end else begin
            finish_read  <= 1'b0;
            finish_write <= 1'b0;
            k_start      <= 1'b0;
            if (state inside {ST_READ, ST_RUN, ST_WRITE})
                cycles <= cycles + 64'd1;
            case (state)
                ST_IDLE: if (start) begin
                    read_addr   <= read_base;
                    read_size   <= stride;
                    write_size  <= stride;
                    num_read_r  <= num_read;
                    num_write_r <= num_write;
                    read_cnt    <= '0;
                    write_cnt   <= '0;
                    cycles      <= '0;
                    if (len_bad(num_read, num_write, ADDR_WID)) begin
                        error <= 1'b1;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        error       <= 1'b0;
                        read_enable <= 1'b1;
                        state       <= ST_READ;
                    end
                end
                ST_READ: if (read_ready) begin
                    if (cnt_more(read_cnt, num_read_r)) begin
                        read_cnt    <= read_cnt + 64'd1;
                        read_addr   <= read_addr + read_size;
                        finish_read <= 1'b1;
                    end else begin
                        read_enable <= 1'b0;
                        k_start     <= 1'b1;
                        state       <= ST_RUN;
                    end
                end
                ST_RUN: if (k_done) begin
                    if (num_write_r == 64'd0) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        write_data   <= host_q;
                        write_addr   <= write_base;
                        write_enable <= 1'b1;
                        state        <= ST_WRITE;
                    end
                end
                ST_WRITE: if (write_ready) begin
                    if (cnt_more(write_cnt, num_write_r)) begin
                        write_cnt    <= write_next;
                        write_addr   <= write_addr + write_size;
                        write_data   <= host_q;
                        finish_write <= 1'b1;
                    end else begin
                        write_enable <= 1'b0;
                        done         <= 1'b1;
                        state        <= ST_DONE;
                    end
                end
                ST_DONE: if (!start) begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kernel_mem_shell.sv
// Directed bench for kernel_mem_shell: host memory and kernel stub are driven here,
// a scratchpad/address model is compared against the DUT every cycle.
module tb_kernel_mem_shell;

    localparam int DW = 32, AW = 12, BB = 2, PT = 2;
    localparam int NB = 4, P = NB * PT, LA = AW - BB;

    logic clk = 1'b0;
    logic reset, start, read_ready, write_ready, k_done;
    logic [63:0] read_base, write_base, num_read, num_write, stride;
    logic [DW-1:0] read_data, write_data;
    logic read_enable, write_enable, finish_read, finish_write, done, error, k_start;
    logic [63:0] read_addr, write_addr, read_size, write_size, cycles;
    logic [P*LA-1:0] k_addr;
    logic [P-1:0] k_ce, k_we;
    logic [P*DW-1:0] k_d, k_q;

    always #5 clk = ~clk;

    kernel_mem_shell #(.DATA_WID(DW), .ADDR_WID(AW), .BANK_BITS(BB), .PORTS(PT)) dut (
        .clk(clk), .reset(reset), .start(start),
        .read_base(read_base), .write_base(write_base),
        .num_read(num_read), .num_write(num_write), .stride(stride),
        .read_ready(read_ready), .read_data(read_data), .write_ready(write_ready),
        .read_enable(read_enable), .write_enable(write_enable),
        .read_addr(read_addr), .write_addr(write_addr),
        .read_size(read_size), .write_size(write_size),
        .finish_read(finish_read), .finish_write(finish_write),
        .write_data(write_data), .done(done), .error(error), .cycles(cycles),
        .k_start(k_start), .k_done(k_done),
        .k_addr(k_addr), .k_ce(k_ce), .k_we(k_we), .k_d(k_d), .k_q(k_q)
    );

    int n_pass = 0, n_chk = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] host_fn(input logic [63:0] a);
        return a[31:0] * 32'h9E37_79B1 + 32'h0000_1357;
    endfunction

    // Model state
    logic [63:0] m_rb, m_wb, m_nr, m_nw, m_st;
    logic [31:0] mm [4096];
    logic [31:0] wr_q [$];
    logic [31:0] kq_exp [P];
    logic [P-1:0] kq_pend;
    int rd_acc, wr_acc, n_fr, n_fw, n_ks, n_we;
    logic fr_exp, fw_exp;
    bit mon_en = 0;

    always @(negedge clk) if (mon_en) begin
        for (int p = 0; p < P; p++)
            if (kq_pend[p]) chk("k_q", 64'(k_q[p*DW +: DW]), 64'(kq_exp[p]));
        kq_pend = '0;
        chk("finish_read", 64'(finish_read), 64'(fr_exp));
        chk("finish_write", 64'(finish_write), 64'(fw_exp));
        fr_exp = 1'b0;
        fw_exp = 1'b0;
        if (finish_read)  n_fr++;
        if (finish_write) n_fw++;
        if (k_start)      n_ks++;
        if (write_enable) n_we++;
        if (read_enable) begin
            chk("read_addr", read_addr, m_rb + m_st * 64'(rd_acc));
            chk("read_size", read_size, m_st);
            if (read_ready) begin
                mm[rd_acc] = read_data;
                fr_exp = (64'(rd_acc) + 64'd1 < m_nr);
                rd_acc++;
            end
        end
        if (write_enable) begin
            chk("write_addr", write_addr, m_wb + m_st * 64'(wr_acc));
            chk("write_size", write_size, m_st);
            chk("write_data", 64'(write_data), 64'(mm[wr_acc]));
            if (write_ready) begin
                wr_q.push_back(write_data);
                fw_exp = (64'(wr_acc) + 64'd1 < m_nw);
                wr_acc++;
            end
        end
        for (int p = 0; p < P; p++) begin
            int ga;
            ga = (p / PT) * 1024 + int'(k_addr[p*LA +: LA]);
            if (k_ce[p] && !k_we[p]) begin
                kq_pend[p] = 1'b1;
                kq_exp[p]  = mm[ga];
            end
        end
        for (int p = P - 1; p >= 0; p--) begin
            int ga;
            ga = (p / PT) * 1024 + int'(k_addr[p*LA +: LA]);
            if (k_ce[p] && k_we[p]) mm[ga] = k_d[p*DW +: DW];
        end
    end

    task automatic kport(input int p, input int a, input bit we, input logic [31:0] d);
        k_ce[p] = 1'b1;
        k_we[p] = we;
        k_addr[p*LA +: LA] = LA'(a);
        k_d[p*DW +: DW] = d;
    endtask

    logic [63:0] res_cycles;
    logic res_err;
    bit res_seen;
    int meas;

    // kmode 0: two kernel reads; 1: same-address write/read script; 2: no kernel traffic.
    task automatic run_case(input logic [63:0] rb, wb, nr, nw, st,
                            input int kmode, input bit rr_tog, input int abort_at);
        int kstep, phase, t;
        m_rb = rb; m_wb = wb; m_nr = nr; m_nw = nw; m_st = st;
        rd_acc = 0; wr_acc = 0; wr_q.delete();
        n_fr = 0; n_fw = 0; n_ks = 0; n_we = 0;
        fr_exp = 1'b0; fw_exp = 1'b0; kq_pend = '0;
        meas = 0; res_seen = 0; kstep = -1; phase = 0;
        read_base = rb; write_base = wb; num_read = nr; num_write = nw; stride = st;
        start = 1'b1;
        mon_en = 1;
        for (t = 0; t < 10000; t++) begin
            @(posedge clk); #1;
            if (done) break;
            if (read_enable) res_seen = 1;
            if (res_seen) meas++;
            if (abort_at > 0 && meas == abort_at) begin
                mon_en = 0;
                start = 1'b0;
                reset = 1'b1;
                #1;
                chk("abort_read_enable", 64'(read_enable), 64'd0);
                chk("abort_cycles", cycles, 64'd0);
                @(negedge clk) reset = 1'b0;
                @(posedge clk); #1;
                return;
            end
            read_ready = read_enable && !(rr_tog && phase[0]);
            if (read_enable) phase++;
            read_data = host_fn(read_addr);
            write_ready = 1'b1;
            k_ce = '0; k_we = '0; k_done = 1'b0;
            if (k_start) kstep = 0;
            if (kstep >= 0) begin
                if (kmode == 0 && kstep == 0) begin
                    kport(0, 3, 0, 32'h0);
                    kport(1, 7, 0, 32'h0);
                end
                if (kmode == 1) begin
                    case (kstep)
                        0: begin kport(0, 5, 1, 32'hA); kport(1, 5, 1, 32'hB); end
                        1: kport(1, 5, 0, 32'h0);
                        2: begin kport(0, 5, 0, 32'h0); kport(1, 5, 1, 32'hC); end
                        default: ;
                    endcase
                end
                if (kstep == 3) begin k_done = 1'b1; kstep = -1; end
                else kstep++;
            end
        end
        chk("done_reached", 64'(done), 64'd1);
        res_cycles = cycles;
        res_err = error;
        chk("cycles_vs_observed", cycles, 64'(meas));
        start = 1'b0;
        @(posedge clk); #1;
        chk("done_clear", 64'(done), 64'd0);
    endtask

    logic [63:0] err_nr [3] = '{64'd4097, 64'd0, 64'd16};
    logic [63:0] err_nw [3] = '{64'd4, 64'd4, 64'd4097};

    initial begin
        reset = 1'b1; start = 1'b0; read_ready = 1'b0; write_ready = 1'b0; k_done = 1'b0;
        read_base = '0; write_base = '0; num_read = '0; num_write = '0; stride = '0;
        read_data = '0; k_addr = '0; k_ce = '0; k_we = '0; k_d = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_read_enable", 64'(read_enable), 64'd0);
        chk("rst_write_enable", 64'(write_enable), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_cycles", cycles, 64'd0);
        chk("rst_k_start", 64'(k_start), 64'd0);
        chk("rst_write_data", 64'(write_data), 64'd0);
        chk("rst_read_addr", read_addr, 64'd0);
        chk("rst_k_q", 64'(k_q[63:0]), 64'd0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

        // Back-to-back transfers, 16 in / 16 out
        run_case(64'h1000, 64'h8000, 16, 16, 4, 0, 0, 0);
        chk("c1_cycles", res_cycles, 64'd36);
        chk("c1_error", 64'(res_err), 64'd0);
        chk("c1_finish_read", 64'(n_fr), 64'd15);
        chk("c1_finish_write", 64'(n_fw), 64'd15);
        chk("c1_k_start", 64'(n_ks), 64'd1);
        for (int i = 0; i < 16; i++)
            chk("c1_wdata", 64'(wr_q[i]), 64'(host_fn(64'h1000 + 64'(4 * i))));

        // read_ready toggling, stride 8
        run_case(64'h2000, 64'h9000, 16, 4, 8, 0, 1, 0);
        chk("c2_cycles", res_cycles, 64'd39);
        chk("c2_finish_read", 64'(n_fr), 64'd15);
        chk("c2_finish_write", 64'(n_fw), 64'd3);
        for (int i = 0; i < 4; i++)
            chk("c2_wdata", 64'(wr_q[i]), 64'(host_fn(64'h2000 + 64'(8 * i))));

        // Length errors
        for (int i = 0; i < 3; i++) begin
            run_case(64'h100, 64'h200, err_nr[i], err_nw[i], 4, 2, 0, 0);
            chk("err_flag", 64'(res_err), 64'd1);
            chk("err_cycles", res_cycles, 64'd0);
            chk("err_read_enable_seen", 64'(res_seen), 64'd0);
            chk("err_write_enable_seen", 64'(n_we), 64'd0);
            chk("err_retained", 64'(error), 64'd1);
        end

        // Same-address kernel writes and read-before-write
        run_case(64'h4000, 64'hA000, 8, 8, 4, 1, 0, 0);
        chk("c4_error_cleared", 64'(res_err), 64'd0);
        chk("c4_cycles", res_cycles, 64'd20);
        chk("c4_kq0", 64'(k_q[0 +: DW]), 64'hA);
        chk("c4_kq1", 64'(k_q[DW +: DW]), 64'hA);
        chk("c4_word5", 64'(wr_q[5]), 64'hC);
        chk("c4_word4", 64'(wr_q[4]), 64'(host_fn(64'h4010)));

        // num_write=0 with read addresses wrapping past 2^64
        run_case(64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 4, 0, 4, 2, 0, 0);
        chk("c5_cycles", res_cycles, 64'd8);
        chk("c5_write_enable_seen", 64'(n_we), 64'd0);
        chk("c5_finish_read", 64'(n_fr), 64'd3);
        chk("c5_wrap_addr", read_addr, 64'h4);

        // Reset mid-READ, then a clean run
        run_case(64'h5000, 64'hB000, 16, 16, 4, 0, 0, 5);
        run_case(64'h6000, 64'hB000, 8, 8, 4, 0, 0, 0);
        chk("c6_cycles", res_cycles, 64'd20);
        for (int i = 0; i < 8; i++)
            chk("c6_wdata", 64'(wr_q[i]), 64'(host_fn(64'h6000 + 64'(4 * i))));

        // Full-depth load
        run_case(64'h0, 64'hC000, 4096, 2, 1, 0, 0, 0);
        chk("c7_error", 64'(res_err), 64'd0);
        chk("c7_cycles", res_cycles, 64'd4102);
        chk("c7_word0", 64'(wr_q[0]), 64'(host_fn(64'h0)));
        chk("c7_word1", 64'(wr_q[1]), 64'(host_fn(64'h1)));

        mon_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
